ysyx_22041412_icache: RTL and testbench
=======================================

Name: ysyx_22041412_icache

Overview:
Direct-mapped instruction cache sitting directly downstream of the IF stage's fetch request port. It serves 128-bit line-aligned reads back to IF through a valid/ready handshake. Misses are refilled from a 64-bit memory read port in two beats. Storage is register arrays; fence_i support invalidates the whole cache.

Parameters:
INDEX_W, 4, line index bits (2^INDEX_W lines of 16 bytes); tag width = 28-INDEX_W

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
valid_i  in  1  fetch request from IF, held until ready_o seen
addr_i  in  32  fetch address; bits [3:0] ignored
ready_o  out  1  one-cycle pulse: data_o valid for current request
data_o  out  128  full line; word k of the line in bits [32k+31:32k]
fence_i  in  1  invalidate-all request, single-cycle pulse
mem_valid_o  out  1  refill read request, held until second beat accepted
mem_addr_o  out  32  refill line address {addr[31:4],4'b0}
mem_ready_i  in  1  mem_data_i beat valid this cycle
mem_data_i  in  64  refill beat data
hit_cnt_o  out  32  lookup hits since reset, wraps 0xFFFFFFFF->0
miss_cnt_o  out  32  lookup misses since reset, wraps

Behaviour:
- Reset: state IDLE; all line valid bits 0; ready_o=0, data_o=0, mem_valid_o=0, mem_addr_o=0, beat counter 0, fence pending 0, both counters 0. Tag/data arrays are not cleared.
- Index = addr[INDEX_W+3:4]; tag = addr[31:INDEX_W+4].
- States: IDLE, LOOKUP, REFILL, RESP.
- IDLE:
  - If fence pending or fence_i: clear all valid bits this cycle, clear pending, stay IDLE; valid_i is ignored this cycle.
  - Else, if valid_i: latch addr_i into req_addr, go to LOOKUP.
- LOOKUP:
  - Hit (valid & tag match): register data_o=line, ready_o=1 for the next cycle, hit_cnt+1, go to IDLE.
  - Miss: miss_cnt+1, mem_valid_o=1, mem_addr_o={req_addr[31:4],4'b0}, beat=0, go to REFILL.
- REFILL:
  - mem_valid_o and mem_addr_o are held stable.
  - On mem_ready_i with beat 0: buffer bits [63:0], beat=1.
  - On mem_ready_i with beat 1: bits [127:64]; write line, tag, valid=1; data_o=full line; mem_valid_o=0; go to RESP.
  - Stall cycles (mem_ready_i=0) change nothing.
- RESP: ready_o=1 for exactly this cycle, then go to IDLE.
- Latency: hit has ready_o two cycles after the valid_i sample edge. Miss has ready_o one cycle after the second beat is accepted.
- ready_o is a one-cycle pulse and is never high in two consecutive cycles. IF drops valid_i on seeing ready_o, so IDLE does not re-trigger.
- data_o holds its value until the next response.
- valid_i dropped mid-request: the request still completes (line installed, ready_o pulses). IF discards the pulse.
- fence_i outside IDLE: set fence pending; the current request completes normally; invalidate on the first IDLE cycle.
- rst mid-REFILL: abort; partial line is not installed. mem_valid_o=0 on the cycle after rst is sampled.
- Same-index different-tag: replace the line unconditionally (no victim writeback; read-only cache).
- Counters increment once per LOOKUP only; there is no increment in other states.

Test Plan:
- Miss: rst, then valid_i addr 0x80000004. Required: mem_valid_o=1, mem_addr_o=0x80000000. Beats 0x00000013_00000093, 0x00100073_00000113 → ready_o pulse with data_o=0x00100073_00000113_00000013_00000093; miss_cnt_o=1.
- Hit: then request 0x8000000C. Required: ready_o two cycles after the sample, same data_o, mem_valid_o stays 0, hit_cnt_o=1.
- Conflict: request 0x80000100 (index 0, new tag). Required: miss, refill at 0x80000100. Then 0x80000000 misses again; miss_cnt_o=3.
- Stall: mem_ready_i low 5 cycles between beats. Required: mem_valid_o and mem_addr_o stable throughout; correct line returned; exactly one ready_o pulse.
- Fence: fence_i pulse during REFILL. Required: response still delivered; valid bits cleared in the following IDLE cycle; a repeat request to the same address misses.
- Reset mid-refill: rst after beat 0. Required: mem_valid_o=0 next cycle, counters 0; a new request to the same line misses with mem_addr_o=line address.

Source files
------------

// File: rtl/ysyx_22041412_icache.sv
// Direct-mapped instruction cache: 16-byte lines held in register arrays,
// refilled from a 64-bit memory port in two beats. fence_i invalidates every line.
module ysyx_22041412_icache #(
   parameter int INDEX_W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_i,
   input  logic [31:0]  addr_i,
   output logic         ready_o,
   output logic [127:0] data_o,
   input  logic         fence_i,
   output logic         mem_valid_o,
   output logic [31:0]  mem_addr_o,
   input  logic         mem_ready_i,
   input  logic [63:0]  mem_data_i,
   output logic [31:0]  hit_cnt_o,
   output logic [31:0]  miss_cnt_o
);

   // state  | meaning
   // IDLE   | waiting for a fetch; applies pending or fresh fence_i first
   // LOOKUP | compare tag of latched request, answer a hit or start a refill
   // REFILL | collecting two 64-bit beats from memory
   // RESP   | ready_o high for the refilled line

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = 28 - INDEX_W;

   typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

   state_t             state, state_nxt;
   logic [27:0]        req_line;
   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic [LINES-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [127:0]       data_mem [LINES];
   logic [63:0]        beat0_buf;
   logic               beat;
   logic               fence_pend;
   logic               hit;

   logic do_fence, take_req, lookup_hit, lookup_miss, refill_lo, refill_done;

   // Byte offset within a line never affects what is returned.
   logic unused_offset;
   assign unused_offset = ^addr_i[3:0];

   assign req_idx = req_line[INDEX_W-1:0];
   assign req_tag = req_line[27:INDEX_W];
   assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and one-cycle action strobes for the datapath.
   always_comb begin
      state_nxt   = state;
      do_fence    = 1'b0;
      take_req    = 1'b0;
      lookup_hit  = 1'b0;
      lookup_miss = 1'b0;
      refill_lo   = 1'b0;
      refill_done = 1'b0;
      case (state)
         IDLE: begin
            if (fence_pend || fence_i) begin
               do_fence = 1'b1;
            end else if (valid_i) begin
               take_req  = 1'b1;
               state_nxt = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               lookup_hit = 1'b1;
               state_nxt  = IDLE;
            end else begin
               lookup_miss = 1'b1;
               state_nxt   = REFILL;
            end
         end
         REFILL: begin
            if (mem_ready_i) begin
               if (!beat) begin
                  refill_lo = 1'b1;
               end else begin
                  refill_done = 1'b1;
                  state_nxt   = RESP;
               end
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control/datapath registers: request, response, refill port, counters, valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_line    <= '0;
         ready_o     <= 1'b0;
         data_o      <= '0;
         mem_valid_o <= 1'b0;
         mem_addr_o  <= '0;
         beat        <= 1'b0;
         beat0_buf   <= '0;
         fence_pend  <= 1'b0;
         hit_cnt_o   <= '0;
         miss_cnt_o  <= '0;
         valid_q     <= '0;
      end else begin
         ready_o <= lookup_hit | refill_done;
         if (take_req) req_line <= addr_i[31:4];
         if (lookup_hit) begin
            data_o    <= data_mem[req_idx];
            hit_cnt_o <= hit_cnt_o + 32'd1;
         end
         if (lookup_miss) begin
            miss_cnt_o  <= miss_cnt_o + 32'd1;
            mem_valid_o <= 1'b1;
            mem_addr_o  <= {req_line, 4'b0000};
            beat        <= 1'b0;
         end
         if (refill_lo) begin
            beat0_buf <= mem_data_i;
            beat      <= 1'b1;
         end
         if (refill_done) begin
            data_o           <= {mem_data_i, beat0_buf};
            mem_valid_o      <= 1'b0;
            beat             <= 1'b0;
            valid_q[req_idx] <= 1'b1;
         end
         if (do_fence) begin
            valid_q    <= '0;
            fence_pend <= 1'b0;
         end else if (fence_i && (state != IDLE)) begin
            fence_pend <= 1'b1;
         end
      end
   end

   // Line storage; no reset needed since valid_q gates every use.
   always_ff @(posedge clk) begin
      if (refill_done && !rst) begin
         data_mem[req_idx] <= {mem_data_i, beat0_buf};
         tag_mem[req_idx]  <= req_tag;
      end
   end

endmodule

// File: tb/tb_ysyx_22041412_icache.sv
// Bench for the instruction cache: acts as IF and as backing memory, and keeps
// a direct-mapped residency model to predict hits, misses, data and counters.
module tb_ysyx_22041412_icache;

   localparam int INDEX_W = 4;
   localparam int LINES   = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid_i;
   logic [31:0]  addr_i;
   logic         ready_o;
   logic [127:0] data_o;
   logic         fence_i;
   logic         mem_valid_o;
   logic [31:0]  mem_addr_o;
   logic         mem_ready_i;
   logic [63:0]  mem_data_i;
   logic [31:0]  hit_cnt_o;
   logic [31:0]  miss_cnt_o;

   ysyx_22041412_icache #(.INDEX_W(INDEX_W)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .addr_i(addr_i),
      .ready_o(ready_o), .data_o(data_o), .fence_i(fence_i),
      .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
      .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   bit          m_valid [LINES];
   logic [31:0] m_tag   [LINES];
   logic [31:0] m_hits;
   logic [31:0] m_misses;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] mem_beat(input logic [31:0] la, input int k);
      if (la == 32'h8000_0000)
         return (k == 0) ? 64'h00000013_00000093 : 64'h00100073_00000113;
      return {la ^ 32'h5a5a_0000 ^ 32'(k), ~la + 32'(k * 7)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_hits   = '0;
      m_misses = '0;
   endtask

   // One IF request; stall = idle cycles between beats; fence_mid pulses fence_i during refill.
   task automatic fetch(input logic [31:0] a, input int stall, input bit fence_mid);
      logic [31:0]  la;
      int           idx;
      logic [31:0]  tg;
      bit           exp_hit;
      logic [127:0] exp_line;
      int cyc, beats, st, last_beat;
      bit got;
      la       = (a >> 4) << 4;
      idx      = int'((a >> 4) % LINES);
      tg       = a >> (INDEX_W + 4);
      exp_hit  = m_valid[idx] && (m_tag[idx] == tg);
      exp_line = {mem_beat(la, 1), mem_beat(la, 0)};
      @(negedge clk);
      valid_i = 1'b1;
      addr_i  = a;
      cyc = 0; beats = 0; st = 0; got = 1'b0; last_beat = -10;
      while (!got && cyc < 300) begin
         @(negedge clk);
         cyc++;
         mem_ready_i = 1'b0;
         fence_i     = 1'b0;
         if (ready_o) begin
            got     = 1'b1;
            valid_i = 1'b0;
            chk("data_o", data_o, exp_line);
            if (exp_hit) chk("hit_latency", 128'(cyc), 128'(2));
            else         chk("miss_latency", 128'(cyc), 128'(last_beat + 1));
         end else if (mem_valid_o) begin
            if (exp_hit) chk("mem_valid_on_hit", 128'(mem_valid_o), 128'(0));
            chk("mem_addr_o", 128'(mem_addr_o), 128'(la));
            if (beats == 1 && st < stall) begin
               st++;
            end else if (beats < 2) begin
               mem_ready_i = 1'b1;
               mem_data_i  = mem_beat(la, beats);
               if (beats == 0 && fence_mid) fence_i = 1'b1;
               if (beats == 1) last_beat = cyc;
               beats++;
            end
         end
      end
      if (!got) chk("ready_timeout", 128'(0), 128'(1));
      @(negedge clk);
      chk("ready_single_pulse", 128'(ready_o), 128'(0));
      if (exp_hit) m_hits++;
      else begin
         m_misses++;
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
         if (fence_mid) for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      end
      chk("hit_cnt_o", 128'(hit_cnt_o), 128'(m_hits));
      chk("miss_cnt_o", 128'(miss_cnt_o), 128'(m_misses));
   endtask

   initial begin
      int n;
      logic [31:0] ra;
      rst = 1'b1; valid_i = 1'b0; addr_i = '0; fence_i = 1'b0;
      mem_ready_i = 1'b0; mem_data_i = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_ready_o", 128'(ready_o), 128'(0));
      chk("rst_data_o", data_o, 128'(0));
      chk("rst_mem_valid_o", 128'(mem_valid_o), 128'(0));
      chk("rst_mem_addr_o", 128'(mem_addr_o), 128'(0));
      chk("rst_hit_cnt", 128'(hit_cnt_o), 128'(0));
      chk("rst_miss_cnt", 128'(miss_cnt_o), 128'(0));
      rst = 1'b0;

      fetch(32'h8000_0004, 0, 1'b0);
      chk("first_line", data_o, 128'h00100073_00000113_00000013_00000093);
      fetch(32'h8000_000C, 0, 1'b0);
      fetch(32'h8000_0100, 0, 1'b0);
      fetch(32'h8000_0000, 0, 1'b0);
      chk("conflict_miss_cnt", 128'(miss_cnt_o), 128'(3));
      fetch(32'h8000_0234, 5, 1'b0);
      fetch(32'h8000_0238, 0, 1'b0);
      fetch(32'h8000_0344, 2, 1'b1);
      fetch(32'h8000_0344, 0, 1'b0);
      fetch(32'h8000_0234, 1, 1'b0);

      // Reset after the first refill beat.
      @(negedge clk);
      valid_i = 1'b1;
      addr_i  = 32'h8000_0520;
      n = 0;
      while (!mem_valid_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_mem_valid_seen", 128'(mem_valid_o), 128'(1));
      mem_ready_i = 1'b1;
      mem_data_i  = mem_beat(32'h8000_0520, 0);
      @(negedge clk);
      mem_ready_i = 1'b0;
      valid_i     = 1'b0;
      rst         = 1'b1;
      @(negedge clk);
      chk("rst_mid_mem_valid_o", 128'(mem_valid_o), 128'(0));
      chk("rst_mid_ready_o", 128'(ready_o), 128'(0));
      chk("rst_mid_hit_cnt", 128'(hit_cnt_o), 128'(0));
      chk("rst_mid_miss_cnt", 128'(miss_cnt_o), 128'(0));
      rst = 1'b0;
      model_reset();
      fetch(32'h8000_0528, 0, 1'b0);
      fetch(32'h8000_052C, 0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         ra = 32'h8000_0000 + ($urandom_range(0, 47) << 4) + $urandom_range(0, 15);
         fetch(ra, int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
